ysyx_22050550_regfile_sb: RTL and testbench
===========================================

# ysyx_22050550_regfile_sb

Parametrised multi-port integer register file with a per-register busy scoreboard and same-cycle write-back bypass. It replaces the single-write, two-read GPR array for the pipelined core. Decode issues destination registers, which are marked busy. Write-back ports commit data and clear busy. Read ports return bypassed operands together with an availability flag, so the issue stage can stall on RAW and WAW hazards.

## Interface
Parameters:
- XLEN, 64, data width of each register
- NREG, 32, number of architectural registers; register 0 is hardwired to zero
- NRP, 2, number of read ports
- NWP, 2, number of write-back ports (1..4)
- AW, $clog2(NREG), register address width (derived, not overridden)

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush; clears every busy bit
- iss_valid  in  1  decode presents an instruction that writes iss_rd
- iss_rd  in  AW  destination register of the issuing instruction
- iss_ready  out  1  issue accepted this cycle (iss_fire = iss_valid & iss_ready)
- wb_en  in  NWP  per-port write enable
- wb_addr  in  NWP*AW  per-port destination; port k occupies bits [k*AW +: AW]
- wb_data  in  NWP*XLEN  per-port write data
- rd_addr  in  NRP*AW  per-port read address
- rd_data  out  NRP*XLEN  per-port read data, bypassed
- rd_ok  out  NRP  operand valid: register not busy, or being written this cycle
- busy_vec  out  NREG  current busy bits; bit 0 is always 0
- wr_conflict  out  1  sticky error flag: two write ports wrote the same non-zero address in one cycle

## Operation
- Storage: NREG-1 flops of XLEN bits. Register 0 reads as 0, ignores writes and is never busy.
- Write: on a clock edge, every port with wb_en=1 and wb_addr≠0 writes wb_data.
- Write collision: if ports share an address, the highest-index port wins, and wr_conflict is set and held until reset.
- Busy clear: each write, with or without a collision, clears busy[wb_addr] at the edge.
- Busy set: iss_fire with iss_rd≠0 sets busy[iss_rd] at the edge.
- Same register set and cleared in one cycle: set wins, because the new producer supersedes the old one.
- iss_ready = ~flush & (iss_rd==0 | ~busy[iss_rd] | some wb port writes iss_rd this cycle). This is the WAW stall; only one producer per register is ever in flight.
- Flush: at the edge, all busy bits become 0. Writes in the same cycle still commit to storage. Issues in the same cycle are refused (iss_ready=0).
- Read: rd_data[p] is 0 if rd_addr[p]==0.
  - Otherwise it is the wb_data of the highest-index port writing that address this cycle.
  - Otherwise it is the stored value.
- rd_ok[p] = (rd_addr[p]==0) | ~busy[rd_addr[p]] | a write to rd_addr[p] this cycle.
- Out-of-range addresses (≥NREG, possible only when NREG is not a power of two): reads return 0 with rd_ok=1; writes and issues to them are ignored.

## Timing
- Reset: all registers = 0, busy_vec = 0, wr_conflict = 0. Asserting reset mid-operation discards all state immediately and asynchronously.
- Read path is combinational from rd_addr, wb_*, and state. Zero-cycle bypass latency; the value appears in storage one cycle after the write.
- iss_ready and rd_ok are combinational and do not depend on iss_valid.
- busy_vec changes only on the clock edge or on reset.
- A register issued in cycle N reads rd_ok=0 from cycle N+1 until its write-back cycle, inclusive of the bypass: it reads rd_ok=1 in the write-back cycle itself.

## Test plan
- Reset → busy_vec=0, rd_data=0 on all ports, wr_conflict=0, iss_ready=1 for iss_rd=5.
- Issue x5, then two cycles later wb port 0 writes x5=64'hDEAD_BEEF → rd_ok=0 for x5 during the stall cycles; in the write-back cycle rd_ok=1 and rd_data=64'hDEAD_BEEF (bypass); next cycle busy_vec[5]=0.
- With x7 busy, iss_valid with iss_rd=7 → iss_ready=0. Same cycle with wb to x7 → iss_ready=1, and after the edge busy_vec[7]=1 (set wins).
- wb ports 0 and 1 both write x3 (0x11, 0x22) → rd_data=0x22 this cycle and after the edge; wr_conflict=1, and it stays 1 after further clean writes.
- Issue/write x0 with 0xFF → iss_ready=1, busy_vec[0]=0, rd_data for x0 = 0.
- Mark x1, x2, x9 busy, then flush with a wb to x2=0x5 and iss_valid to x4 → next cycle busy_vec=0, x2=0x5, x4 not busy; asynchronous reset mid-stall → all busy and data cleared immediately.

Source files
------------

// File: rtl/ysyx_22050550_regfile_sb.sv
// Multi-port integer register file with per-register busy scoreboard and
// same-cycle write-back bypass on the read and issue paths.
module ysyx_22050550_regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int NWP  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic [NWP-1:0]      wb_en,
  input  logic [NWP*AW-1:0]   wb_addr,
  input  logic [NWP*XLEN-1:0] wb_data,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_ok,
  output logic [NREG-1:0]     busy_vec,
  output logic                wr_conflict
);

  localparam logic [AW:0] NREG_W = NREG[AW:0];

  logic [XLEN-1:0] regs [1:NREG-1];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            conflict_now;
  logic            iss_fire;
  logic [XLEN:0]   iss_byp;

  // Non-zero and inside the implemented register range.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREG_W);
  endfunction

  // Returns {hit, data}; later ports overwrite earlier ones so the highest index wins.
  function automatic logic [XLEN:0] bypass(
    input logic [AW-1:0]       a,
    input logic [NWP-1:0]      en,
    input logic [NWP*AW-1:0]   ad,
    input logic [NWP*XLEN-1:0] dt
  );
    logic [XLEN:0] r;
    r = '0;
    for (int unsigned k = 0; k < NWP; k++) begin
      if (en[k] && ad[k*AW +: AW] == a) r = {1'b1, dt[k*XLEN +: XLEN]};
    end
    return r;
  endfunction

  always_comb begin
    iss_byp   = bypass(iss_rd, wb_en, wb_addr, wb_data);
    iss_ready = ~flush & (~addr_ok(iss_rd) | ~busy[iss_rd] | iss_byp[XLEN]);
    iss_fire  = iss_valid & iss_ready;
  end

  always_comb begin
    logic [AW-1:0] a;
    logic [XLEN:0] byp;
    rd_data = '0;
    rd_ok   = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      a   = rd_addr[p*AW +: AW];
      byp = bypass(a, wb_en, wb_addr, wb_data);
      if (!addr_ok(a)) begin
        rd_data[p*XLEN +: XLEN] = '0;
        rd_ok[p]                = 1'b1;
      end else if (byp[XLEN]) begin
        rd_data[p*XLEN +: XLEN] = byp[XLEN-1:0];
        rd_ok[p]                = 1'b1;
      end else begin
        rd_data[p*XLEN +: XLEN] = regs[a];
        rd_ok[p]                = ~busy[a];
      end
    end
  end

  always_comb begin
    conflict_now = 1'b0;
    for (int unsigned j = 0; j < NWP; j++) begin
      for (int unsigned k = j + 1; k < NWP; k++) begin
        if (wb_en[j] && wb_en[k] && addr_ok(wb_addr[j*AW +: AW]) &&
            wb_addr[j*AW +: AW] == wb_addr[k*AW +: AW])
          conflict_now = 1'b1;
      end
    end
  end

  // Clear on write-back, then set on issue so a new producer supersedes the old one.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned k = 0; k < NWP; k++) begin
      if (wb_en[k] && addr_ok(wb_addr[k*AW +: AW])) busy_nxt[wb_addr[k*AW +: AW]] = 1'b0;
    end
    if (iss_fire && addr_ok(iss_rd)) busy_nxt[iss_rd] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      busy        <= busy_nxt;
      wr_conflict <= wr_conflict | conflict_now;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 1; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int unsigned k = 0; k < NWP; k++) begin
        if (wb_en[k] && addr_ok(wb_addr[k*AW +: AW]))
          regs[wb_addr[k*AW +: AW]] <= wb_data[k*XLEN +: XLEN];
      end
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_ysyx_22050550_regfile_sb.sv
// Directed self-checking bench for ysyx_22050550_regfile_sb (default parameters).
module tb_ysyx_22050550_regfile_sb;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int NWP  = 2;
  localparam int AW   = 5;

  logic                clock = 1'b0;
  logic                reset;
  logic                flush;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_ready;
  logic [NWP-1:0]      wb_en;
  logic [NWP*AW-1:0]   wb_addr;
  logic [NWP*XLEN-1:0] wb_data;
  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_ok;
  logic [NREG-1:0]     busy_vec;
  logic                wr_conflict;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_22050550_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ok(rd_ok),
    .busy_vec(busy_vec), .wr_conflict(wr_conflict)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush     = 1'b0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    wb_en     = '0;
    wb_addr   = '0;
    wb_data   = '0;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wb(input int port, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wb_en[port]              = 1'b1;
    wb_addr[port*AW +: AW]   = a;
    wb_data[port*XLEN +: XLEN] = d;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    iss_valid = 1'b1;
    iss_rd    = a;
  endtask

  initial begin
    reset   = 1'b0;
    rd_addr = '0;
    idle();
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Reset state
    rd_addr = {5'd3, 5'd5};
    iss_rd  = 5'd5;
    #1;
    check("rst_busy", busy_vec, 64'h0);
    check("rst_rd0", rd_data[63:0], 64'h0);
    check("rst_rd1", rd_data[127:64], 64'h0);
    check("rst_conf", wr_conflict, 64'h0);
    check("rst_ready", iss_ready, 64'h1);

    // Issue x5, write back two cycles later via port 0
    step(); idle(); issue(5'd5); #1;
    check("iss5_ready", iss_ready, 64'h1);
    step(); idle(); #1;
    check("x5_stall1_ok", rd_ok[0], 64'h0);
    check("x5_busy", busy_vec[5], 64'h1);
    step(); idle(); #1;
    check("x5_stall2_ok", rd_ok[0], 64'h0);
    step(); idle(); wb(0, 5'd5, 64'hDEAD_BEEF); #1;
    check("x5_wb_ok", rd_ok[0], 64'h1);
    check("x5_wb_byp", rd_data[63:0], 64'hDEAD_BEEF);
    step(); idle(); #1;
    check("x5_clear", busy_vec[5], 64'h0);
    check("x5_stored", rd_data[63:0], 64'hDEAD_BEEF);

    // WAW stall on x7, then set-wins when issue and write-back coincide
    issue(5'd7);
    step(); idle(); issue(5'd7); #1;
    check("x7_waw_stall", iss_ready, 64'h0);
    wb(1, 5'd7, 64'h77); #1;
    check("x7_wb_ready", iss_ready, 64'h1);
    step(); idle(); rd_addr = {5'd3, 5'd7}; #1;
    check("x7_set_wins", busy_vec[7], 64'h1);
    check("x7_rdok", rd_ok[0], 64'h0);
    check("x7_data", rd_data[63:0], 64'h77);

    // Two ports write x3: highest index wins, sticky conflict
    wb(0, 5'd3, 64'h11); wb(1, 5'd3, 64'h22); #1;
    check("x3_byp", rd_data[127:64], 64'h22);
    check("x3_noconf_yet", wr_conflict, 64'h0);
    step(); idle(); #1;
    check("x3_stored", rd_data[127:64], 64'h22);
    check("conf_set", wr_conflict, 64'h1);
    wb(0, 5'd10, 64'hAB);
    step(); idle(); rd_addr = {5'd10, 5'd7}; #1;
    check("conf_sticky", wr_conflict, 64'h1);
    check("x10_stored", rd_data[127:64], 64'hAB);

    // Register 0 is never busy and reads zero
    rd_addr = {5'd0, 5'd7};
    issue(5'd0); wb(0, 5'd0, 64'hFF); #1;
    check("x0_ready", iss_ready, 64'h1);
    check("x0_byp", rd_data[127:64], 64'h0);
    check("x0_ok", rd_ok[1], 64'h1);
    step(); idle(); #1;
    check("x0_busy", busy_vec[0], 64'h0);
    check("x0_rd", rd_data[127:64], 64'h0);
    check("busy_only7", busy_vec, 64'h80);

    // Mark x1, x2, x9 busy, then flush with a write and an issue
    issue(5'd1); step(); idle();
    issue(5'd2); step(); idle();
    issue(5'd9); step(); idle(); #1;
    check("pre_flush_busy", busy_vec, 64'h286);
    flush = 1'b1; wb(0, 5'd2, 64'h5); issue(5'd4); #1;
    check("flush_ready", iss_ready, 64'h0);
    step(); idle(); rd_addr = {5'd4, 5'd2}; #1;
    check("flush_busy", busy_vec, 64'h0);
    check("flush_x2", rd_data[63:0], 64'h5);
    check("flush_x4_ok", rd_ok[1], 64'h1);

    // Asynchronous reset in the middle of a stall
    issue(5'd2); step(); idle(); #1;
    check("x2_busy_again", busy_vec, 64'h4);
    #1 reset = 1'b0; #1;
    check("arst_busy", busy_vec, 64'h0);
    check("arst_x2", rd_data[63:0], 64'h0);
    check("arst_conf", wr_conflict, 64'h0);
    step(); reset = 1'b1; #1;
    check("arst_rdok", rd_ok[0], 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
